// File: rtl/d_pipe_pkg.sv
// Shared constants and helpers for the elastic D-register pipeline.
package d_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   function automatic int occ_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage: a data register plus its valid bit.
module d_pipe_stage
   import d_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             valid_q;
   logic             valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         valid_d = valid_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/d_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with valid/ready at both ends,
// synchronous flush, complemented output and registered occupancy.
module d_pipe_reg
   import d_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              OW        = occ_width(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [OW-1:0]    occupancy
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] can_ld;
   logic [WIDTH-1:0] data [DEPTH];
   logic             accept;
   logic [OW-1:0]    occ_q;
   logic [OW-1:0]    occ_d;

   // Ready ripples from the consumer back to the producer, unregistered.
   always_comb begin
      adv           = '0;
      can_ld        = '0;
      adv[DEPTH-1]  = valid[DEPTH-1] & out_ready;
      can_ld[DEPTH-1] = !valid[DEPTH-1] | adv[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i]    = valid[i] & can_ld[i+1];
         can_ld[i] = !valid[i] | adv[i];
      end
   end

   assign in_ready = can_ld[0] & !flush;
   assign accept   = in_valid & in_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             ld;
      logic [WIDTH-1:0] din;

      if (i == 0) begin : g_in
         assign ld  = accept;
         assign din = d;
      end else begin : g_mid
         assign ld  = adv[i-1] & !flush;
         assign din = data[i-1];
      end

      d_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clock   (clock),
         .reset_n (reset_n),
         .load_i  (ld),
         .clear_i (adv[i] | flush),
         .data_i  (din),
         .valid_i (1'b1),
         .data_o  (data[i]),
         .valid_o (valid[i])
      );
   end

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (accept && !adv[DEPTH-1]) begin
         occ_d = occ_q + OW'(1);
      end else if (!accept && adv[DEPTH-1]) begin
         occ_d = occ_q - OW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign q         = data[DEPTH-1];
   assign q_bar     = ~data[DEPTH-1];
   assign out_valid = valid[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_d_pipe_reg.sv
// Scoreboard bench for d_pipe_reg with directed vectors.
module tb_d_pipe_reg;

   localparam int W  = 8;
   localparam int DP = 4;
   localparam int OW = 3;

   logic          clock;
   logic          reset_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  d;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  q;
   logic [W-1:0]  q_bar;
   logic [OW-1:0] occupancy;

   int            vecs;
   int            errs;
   int            n_pop;
   logic [W-1:0]  sb[$];

   d_pipe_reg #(
      .WIDTH     (W),
      .DEPTH     (DP),
      .RESET_VAL (8'h00)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .q_bar     (q_bar),
      .occupancy (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Monitor: inputs are stable at the falling edge, so the handshakes
   // seen here are the ones that complete at the next rising edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            vecs++;
            n_pop++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL unexpected_out: got q=%0h expected none", q);
            end else begin
               logic [W-1:0] e;
               e = sb.pop_front();
               if (q !== e || q_bar !== ~e) begin
                  errs++;
                  $display("FAIL out_word: got q=%0h q_bar=%0h expected %0h/%0h",
                           q, q_bar, e, ~e);
               end
            end
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
            sb.push_back(d);
         end
      end
   end

   initial begin
      vecs      = 0;
      errs      = 0;
      n_pop     = 0;
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d         = '0;

      for (int i = 0; i < 4; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         d        = 8'($urandom);
         step();
      end
      chk("rst_q", q, 8'h00);
      chk("rst_qbar", q_bar, 8'hFF);
      chk("rst_ov", out_valid, 0);
      chk("rst_occ", occupancy, 0);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1;
      chk("rel_ir", in_ready, 1);

      // Streaming
      out_ready = 1'b1;
      in_valid  = 1'b1;
      d         = 8'h11;
      step();
      d = 8'h22;
      step();
      d = 8'h33;
      step();
      in_valid = 1'b0;
      chk("lat_early", out_valid, 0);
      step();
      chk("lat_ov", out_valid, 1);
      chk("s_q0", q, 8'h11);
      chk("s_qb0", q_bar, 8'hEE);
      step();
      chk("s_q1", q, 8'h22);
      chk("s_qb1", q_bar, 8'hDD);
      step();
      chk("s_q2", q, 8'h33);
      chk("s_qb2", q_bar, 8'hCC);
      step();
      chk("s_done", out_valid, 0);
      chk("s_occ", occupancy, 0);

      // Back-pressure and full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d = 8'hA1; step();
      d = 8'hA2; step();
      d = 8'hA3; step();
      d = 8'hA4; step();
      d = 8'hA5;
      #1;
      chk("full_occ", occupancy, 4);
      chk("full_ir", in_ready, 0);
      step();
      step();
      chk("stall_q", q, 8'hA1);
      chk("stall_occ", occupancy, 4);
      out_ready = 1'b1;
      #1;
      chk("pop_ir", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("pp_occ", occupancy, 4);
      chk("pp_q", q, 8'hA2);
      for (int i = 0; i < 4; i++) step();
      chk("bp_occ", occupancy, 0);

      // Simultaneous push/pop while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = 8'hB0 + 8'(i);
         step();
      end
      out_ready = 1'b1;
      for (int i = 4; i < 14; i++) begin
         d = 8'hB0 + 8'(i);
         #1;
         chk("sim_ir", in_ready, 1);
         step();
         chk("sim_occ", occupancy, 4);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("sim_empty", occupancy, 0);

      // Flush with a pending input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d = 8'hC1; step();
      d = 8'hC2; step();
      d = 8'hC3; step();
      chk("fl_occ3", occupancy, 3);
      flush = 1'b1;
      d     = 8'h5A;
      #1;
      chk("fl_ir", in_ready, 0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", occupancy, 0);
      chk("fl_ov", out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("fl_noout", out_valid, 0);
      end

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d = 8'hD1; step();
      d = 8'hD2; step();
      in_valid = 1'b0;
      chk("ar_occ2", occupancy, 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_q", q, 8'h00);
      chk("ar_qbar", q_bar, 8'hFF);
      chk("ar_ov", out_valid, 0);
      chk("ar_occ", occupancy, 0);
      step();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("ar_stale", out_valid, 0);
      end
      in_valid = 1'b1;
      d        = 8'hE7;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("ar_new_ov", out_valid, 1);
      chk("ar_new_q", q, 8'hE7);
      step();

      chk("sb_empty", sb.size(), 0);
      chk("pop_count", n_pop, 23);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/d_pipe_reg.md
Name: d_pipe_reg

Overview:
- Parametrised, elastic successor to the single-bit D storage element.
- A DEPTH-stage, WIDTH-bit register pipeline built from edge-triggered D stages.
- Each stage has a valid bit; a valid/ready handshake runs at both ends; stalled stages hold their data.
- Provides true and complemented outputs (q, q_bar) and a synchronous flush.
- Used as a retiming/delay buffer between producer and consumer blocks on one clock.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, 0, WIDTH-bit value loaded into every stage data register on reset

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all stage valid bits
- in_valid  input  1  producer presents d this cycle
- in_ready  output  1  pipeline accepts d this cycle
- d  input  WIDTH  input data
- out_valid  output  1  q holds valid data
- out_ready  input  1  consumer takes q this cycle
- q  output  WIDTH  last-stage data
- q_bar  output  WIDTH  bitwise inverse of q, always
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, registered

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (ports named clock and reset_n).
- Reset (reset_n=0, asynchronous, no clock needed):
  - all stage valids = 0; all stage data = RESET_VAL
  - out_valid=0, q=RESET_VAL, q_bar=~RESET_VAL, occupancy=0
- Stage index 0 is the input stage, DEPTH-1 the output stage.
  - q = data[DEPTH-1]; out_valid = valid[DEPTH-1]
- Advance rule, combinational from the output backwards:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready
  - stage i can load = !valid[i] | adv[i]
  - adv[i] = valid[i] & (stage i+1 can load), for i < DEPTH-1
- in_ready = (!valid[0] | adv[0]) & !flush. There is a combinational path from out_ready to in_ready; the ready chain is not registered.
- Accept = in_valid & in_ready. On accept, data[0] <= d and valid[0] <= 1 at the next edge.
- Stage i (i>0) loads data[i-1] and valid[i-1] when adv[i-1]. Otherwise it clears its valid if adv[i], or holds.
- Stalled stage: data and valid held exactly; q is stable while out_valid & !out_ready.
- Latency: DEPTH cycles from accept to out_valid with no back-pressure. Throughput is 1 word/cycle with out_ready held 1.
- Full: all DEPTH valids set and out_ready=0 -> in_ready=0; d is ignored even if in_valid=1.
- Full plus out_ready=1 in the same cycle: output word leaves, chain shifts, in_ready=1 and a new word is accepted (no bubble).
- Empty: out_valid=0; q shows the last data held in stage DEPTH-1 and is not cleared.
- Flush=1 at a clock edge:
  - all valids <= 0; data registers untouched; occupancy <= 0
  - the input is not accepted that cycle; any output handshake in that cycle is still treated as consumed by the consumer
- occupancy: registered popcount of the valid bits after the edge. It never exceeds DEPTH.
- DEPTH=1: the single stage is both input and output; the same rules apply.
- reset_n asserted mid-transfer: all in-flight words are discarded immediately and outputs return to reset values.
- Data crossing is bit-exact; no arithmetic is performed.

Decomposition:
- Package d_pipe_pkg: default WIDTH/DEPTH constants and a function for the occupancy width ($clog2(DEPTH+1) with minimum 1).
- Sub-module d_pipe_stage holds one data register plus its valid bit, with reset_n, load, clear and hold controls. It is instantiated DEPTH times in a generate loop.
- Top level owns the advance/ready chain, flush, q_bar and the occupancy counter.

Test Plan:
- Reset: hold reset_n=0 with random d/in_valid -> q=8'h00, q_bar=8'hFF, out_valid=0, occupancy=0. Release -> in_ready=1.
- Streaming: out_ready=1, feed 8'h11, 8'h22, 8'h33 back-to-back -> out_valid first high 4 cycles after the first accept; q = 11, 22, 33 on consecutive cycles; q_bar = EE, DD, CC.
- Back-pressure/full: out_ready=0, push 5 words A1..A5 -> A1..A4 accepted, in_ready=0 at occupancy=4, A5 held off. Then raise out_ready=1 -> A1 out and A5 accepted in the same cycle; all words appear in order.
- Simultaneous full push/pop: occupancy=4, in_valid=1, out_ready=1 for 10 cycles -> occupancy stays 4 and no word is lost or duplicated.
- Flush: occupancy=3, assert flush one cycle with in_valid=1 and d=8'h5A -> next cycle occupancy=0, out_valid=0, 8'h5A never appears at q.
- Async reset mid-stream: drop reset_n between clock edges with occupancy=2 -> outputs go to reset values immediately, without waiting for an edge; after release, no stale word appears.
